// File: rtl/trace_tx_pkg.sv
// Shared constants, event record and frame byte formatting for the pipeline trace stream.
package trace_tx_pkg;

  localparam logic [7:0] TRACE_SYNC      = 8'hA5;
  localparam int         TRACE_FRAME_LEN = 7;

  // B1 layout: {stall[1:0], branch, ovf, rd_name[3:0]}
  localparam int B1_STALL_LSB = 6;
  localparam int B1_BRANCH    = 5;
  localparam int B1_OVF       = 4;

  typedef struct packed {
    logic [1:0]  stall;
    logic        branch;
    logic        wb;
    logic [3:0]  rd;
    logic [15:0] data;
    logic [15:0] addr;
  } trace_rec_t;

  typedef enum logic {ST_IDLE, ST_SEND} tx_state_e;

  // A branch-only event carries zero rd/data regardless of what the core drove.
  function automatic logic [7:0] frame_byte(trace_rec_t r, logic ovf, logic [2:0] idx);
    logic [7:0]  b1;
    logic [15:0] d;
    b1 = '0;
    b1[B1_STALL_LSB +: 2] = r.stall;
    b1[B1_BRANCH]         = r.branch;
    b1[B1_OVF]            = ovf;
    b1[3:0]               = r.wb ? r.rd : 4'h0;
    d                     = r.wb ? r.data : 16'h0;
    case (idx)
      3'd0:    frame_byte = TRACE_SYNC;
      3'd1:    frame_byte = b1;
      3'd2:    frame_byte = r.addr[15:8];
      3'd3:    frame_byte = r.addr[7:0];
      3'd4:    frame_byte = d[15:8];
      3'd5:    frame_byte = d[7:0];
      default: frame_byte = b1 ^ r.addr[15:8] ^ r.addr[7:0] ^ d[15:8] ^ d[7:0];
    endcase
  endfunction

endpackage

// File: rtl/trace_tx_if.sv
// Valid/ready byte stream from the trace serializer to its sink.
interface trace_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/trace_tx_fifo.sv
// Synchronous event FIFO; pointers carry an extra wrap bit to tell full from empty.
module trace_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/trace_tx.sv
// Captures core writeback/branch events into a FIFO and serializes them as 7-byte frames.
module trace_tx
  import trace_tx_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   wb_i,
  input  logic [3:0]             wb_rd_name_i,
  input  logic [DATA_W-1:0]      wb_rd_data_i,
  input  logic [ADDR_W-1:0]      origaddr_i,
  input  logic                   branch_i,
  input  logic [1:0]             stall_i,
  trace_tx_if.master             tx,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [7:0]             drop_cnt_o
);

  trace_rec_t ev_rec, fifo_rd, cur_rec;
  tx_state_e  state;
  logic [2:0] idx;
  logic       ev, pop, drop, fifo_full, fifo_empty;
  logic       ovf_flag, cur_ovf;

  assign ev   = en_i & (wb_i | branch_i);
  assign pop  = (state == ST_IDLE) & ~fifo_empty;
  assign drop = ev & fifo_full & ~pop;

  always_comb begin
    ev_rec        = '0;
    ev_rec.stall  = stall_i;
    ev_rec.branch = branch_i;
    ev_rec.wb     = wb_i;
    ev_rec.rd     = wb_rd_name_i;
    ev_rec.data   = wb_rd_data_i;
    ev_rec.addr   = origaddr_i;
  end

  trace_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(trace_rec_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ev),
    .wdata (ev_rec),
    .pop   (pop),
    .rdata (fifo_rd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  // Drop and frame load never share an edge, so the flag has a single writer per edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_o <= 8'h00;
      ovf_flag   <= 1'b0;
    end else if (drop) begin
      if (drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'h01;
      ovf_flag <= 1'b1;
    end else if (pop) begin
      ovf_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      idx         <= 3'd0;
      cur_rec     <= '0;
      cur_ovf     <= 1'b0;
      tx.tx_valid <= 1'b0;
      tx.tx_data  <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state       <= ST_SEND;
            idx         <= 3'd0;
            cur_rec     <= fifo_rd;
            cur_ovf     <= ovf_flag;
            tx.tx_valid <= 1'b1;
            tx.tx_data  <= TRACE_SYNC;
          end
        end
        ST_SEND: begin
          if (tx.tx_ready) begin
            if (idx == 3'(TRACE_FRAME_LEN - 1)) begin
              state       <= ST_IDLE;
              tx.tx_valid <= 1'b0;
              tx.tx_data  <= 8'h00;
            end else begin
              idx        <= idx + 3'd1;
              tx.tx_data <= frame_byte(cur_rec, cur_ovf, idx + 3'd1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_tx.sv
// Directed bench for trace_tx: table of single-frame vectors plus overflow, backpressure and reset sequences.
module tb_trace_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, wb = 1'b0, br = 1'b0;
  logic [3:0]  rd = '0;
  logic [15:0] data = '0, addr = '0;
  logic [1:0]  st = '0;
  logic [3:0]  level;
  logic [7:0]  drop;

  int checks = 0;
  int failures = 0;

  trace_tx_if tx_if ();

  trace_tx #(.DEPTH(8), .DATA_W(16), .ADDR_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en),
    .wb_i         (wb),
    .wb_rd_name_i (rd),
    .wb_rd_data_i (data),
    .origaddr_i   (addr),
    .branch_i     (br),
    .stall_i      (st),
    .tx           (tx_if.master),
    .level_o      (level),
    .drop_cnt_o   (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Stream monitor: records accepted bytes and checks that a stalled byte is held.
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) chk("hold", {tx_if.tx_valid, tx_if.tx_data}, {1'b1, prev_data});
      if (tx_if.tx_valid && tx_if.tx_ready) q.push_back(tx_if.tx_data);
      prev_hold <= tx_if.tx_valid && !tx_if.tx_ready;
      prev_data <= tx_if.tx_data;
    end
  end

  // Indexed event generator; wb=0 events still drive nonzero rd/data to exercise masking.
  function automatic logic ev_wb(int i); return (i % 4) != 3; endfunction
  function automatic logic ev_br(int i); return (i % 2 == 1) || !ev_wb(i); endfunction

  task automatic set_ev(input int i);
    en   = 1'b1;
    wb   = ev_wb(i);
    br   = ev_br(i);
    rd   = 4'(i);
    data = 16'h1000 + 16'(i) * 16'h0111;
    addr = 16'h0200 + 16'(i);
    st   = 2'(i);
  endtask

  task automatic clr_ev();
    wb = 1'b0;
    br = 1'b0;
  endtask

  task automatic push_frame(input int i, input logic ovf);
    logic [7:0]  b1;
    logic [15:0] d, a;
    logic [2:0]  s;
    s  = 3'(i);
    a  = 16'h0200 + 16'(i);
    d  = ev_wb(i) ? 16'h1000 + 16'(i) * 16'h0111 : 16'h0;
    b1 = {s[1:0], ev_br(i), ovf, ev_wb(i) ? 4'(i) : 4'h0};
    exp_q.push_back(8'hA5);
    exp_q.push_back(b1);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(b1 ^ a[15:8] ^ a[7:0] ^ d[15:8] ^ d[7:0]);
  endtask

  task automatic cmp_q(input string name);
    chk($sformatf("%s bytes", name), 64'(q.size()), 64'(exp_q.size()));
    for (int k = 0; k < q.size() && k < exp_q.size(); k++)
      chk($sformatf("%s byte%0d", name, k), 64'(q[k]), 64'(exp_q[k]));
  endtask

  typedef struct {
    logic        wb;
    logic [3:0]  rd;
    logic [15:0] data;
    logic [15:0] addr;
    logic        br;
    logic [1:0]  st;
    logic [0:6][7:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{1'b1, 4'h3, 16'h1234, 16'h0040, 1'b0, 2'b00,
                {8'hA5, 8'h03, 8'h00, 8'h40, 8'h12, 8'h34, 8'h65}};
    vecs[1] = '{1'b0, 4'hF, 16'hFFFF, 16'h0100, 1'b1, 2'b10,
                {8'hA5, 8'hA0, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA1}};
    vecs[2] = '{1'b1, 4'hA, 16'hBEEF, 16'hC0DE, 1'b1, 2'b01,
                {8'hA5, 8'h6A, 8'hC0, 8'hDE, 8'hBE, 8'hEF, 8'h25}};
    vecs[3] = '{1'b1, 4'h0, 16'h0000, 16'hFFFF, 1'b0, 2'b11,
                {8'hA5, 8'hC0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hC0}};

    tx_if.tx_ready = 1'b1;
    #2;
    chk("rst valid", 64'(tx_if.tx_valid), 0);
    chk("rst data", 64'(tx_if.tx_data), 0);
    chk("rst level", 64'(level), 0);
    chk("rst drop", 64'(drop), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single frames: latency, byte order, checksum, return to idle.
    for (int v = 0; v < 4; v++) begin
      en = 1'b1; wb = vecs[v].wb; rd = vecs[v].rd; data = vecs[v].data;
      addr = vecs[v].addr; br = vecs[v].br; st = vecs[v].st;
      @(posedge clk); #1;
      clr_ev();
      @(negedge clk);
      chk($sformatf("v%0d idle valid", v), 64'(tx_if.tx_valid), 0);
      chk($sformatf("v%0d level1", v), 64'(level), 1);
      for (int k = 0; k < 7; k++) begin
        @(negedge clk);
        chk($sformatf("v%0d B%0d", v, k), {tx_if.tx_valid, tx_if.tx_data}, {1'b1, vecs[v].exp[k]});
        if (k == 0) chk($sformatf("v%0d level0", v), 64'(level), 0);
      end
      @(negedge clk);
      chk($sformatf("v%0d end valid", v), 64'(tx_if.tx_valid), 0);
      @(posedge clk); #1;
    end

    // Overflow: one frame stalled in flight, then 10 events into an 8-deep FIFO.
    q.delete(); exp_q.delete();
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      set_ev(i);
      @(posedge clk); #1;
    end
    clr_ev();
    @(negedge clk);
    chk("ovf level", 64'(level), 8);
    chk("ovf drop", 64'(drop), 2);
    chk("ovf stall B0", {tx_if.tx_valid, tx_if.tx_data}, {1'b1, 8'hA5});

    // Full FIFO: event on the same edge as a frame load is accepted.
    @(posedge clk); #1;
    tx_if.tx_ready = 1'b1;
    begin
      logic found;
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
        @(negedge clk);
        if (!tx_if.tx_valid) found = 1'b1;
      end
      chk("idle gap seen", 64'(found), 1);
    end
    set_ev(11);
    @(posedge clk); #1;
    clr_ev();
    @(negedge clk);
    chk("full push level", 64'(level), 8);
    chk("full push drop", 64'(drop), 2);
    chk("full push load", {tx_if.tx_valid, tx_if.tx_data}, {1'b1, 8'hA5});
    begin
      logic done;
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge clk);
        if (level == 0 && !tx_if.tx_valid) done = 1'b1;
      end
      chk("drain done", 64'(done), 1);
    end
    push_frame(0, 1'b0);
    push_frame(1, 1'b1);
    for (int i = 2; i <= 8; i++) push_frame(i, 1'b0);
    push_frame(11, 1'b0);
    cmp_q("ovf");

    // Random backpressure across two frames.
    @(posedge clk); #1;
    q.delete(); exp_q.delete();
    push_frame(12, 1'b0);
    push_frame(13, 1'b0);
    for (int c = 0; c < 400 && q.size() < 14; c++) begin
      tx_if.tx_ready = 1'($urandom_range(0, 1));
      if (c == 0) set_ev(12);
      else if (c == 1) set_ev(13);
      else clr_ev();
      @(posedge clk); #1;
    end
    clr_ev();
    tx_if.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp_q("rand");

    // Reset while byte 3 is on the wire.
    set_ev(5);
    @(posedge clk); #1;
    clr_ev();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre-rst B3", {tx_if.tx_valid, tx_if.tx_data}, {1'b1, 8'h05});
    rst = 1'b0;
    #1;
    chk("mid rst valid", 64'(tx_if.tx_valid), 0);
    chk("mid rst level", 64'(level), 0);
    chk("mid rst drop", 64'(drop), 0);
    @(negedge clk);
    rst = 1'b1;
    begin
      int vcnt;
      vcnt = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (tx_if.tx_valid) vcnt++;
      end
      chk("post rst quiet", 64'(vcnt), 0);
      chk("post rst level", 64'(level), 0);
      @(posedge clk); #1;
      en = 1'b0;
      for (int c = 0; c < 6; c++) begin
        wb = 1'b1; br = 1'b1; rd = 4'(c); addr = 16'(c);
        @(posedge clk); #1;
      end
      clr_ev();
      vcnt = 0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (tx_if.tx_valid) vcnt++;
      end
      chk("en0 no frames", 64'(vcnt), 0);
      chk("en0 level", 64'(level), 0);
      chk("en0 drop", 64'(drop), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
